// File: rtl/mem_access_unit.sv
// Load/store controller between the execute stage and a single-port BRAM data memory.
// Latency: store 2 cycles, load READ_LAT+2 cycles, misaligned/out-of-range error 1 cycle.
// Backpressure: one access in flight; req_ready low and stall high while in ACCESS/WAIT.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/write/addr/wdata    request from the execute stage (byte address)
//   req_ready, stall              accept strobe / upstream freeze, decoded from state
//   resp_valid/rdata, err_*       registered one-cycle completion with load data and error flags
//   mem_en/we/addr/wdata, rdata   BRAM port; enable and write-enable are one-cycle pulses
module mem_access_unit #(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 32,
  parameter int          READ_LAT  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              err_misaligned,
  output logic              err_range,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        is_write;   // kind of the access currently in flight
  logic [1:0]  cnt;        // remaining WAIT cycles minus one
  logic        accept;
  logic        bad_align;
  logic        bad_range;

  always_comb begin
    req_ready = 1'b0;
    stall     = 1'b0;
    accept    = 1'b0;
    bad_align = |req_addr[1:0];
    bad_range = (req_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
    state_nxt = state;

    case (state)
      IDLE, RESP: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) begin
          // Faulty requests skip the memory and answer straight from RESP.
          state_nxt = (bad_align || bad_range) ? RESP : ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        stall     = 1'b1;
        state_nxt = is_write ? RESP : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 2'd0) begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_write       <= 1'b0;
      cnt            <= 2'd0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      err_misaligned <= 1'b0;
      err_range      <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below.
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      resp_valid     <= 1'b0;
      err_misaligned <= 1'b0;
      err_range      <= 1'b0;

      if (accept) begin
        if (bad_align || bad_range) begin
          resp_valid     <= 1'b1;
          err_misaligned <= bad_align;
          err_range      <= bad_range;
          resp_rdata     <= '0;
        end else begin
          mem_en    <= 1'b1;
          mem_we    <= req_write;
          mem_addr  <= req_addr[ADDR_W+1:2];
          mem_wdata <= req_wdata;
          is_write  <= req_write;
        end
      end

      case (state)
        ACCESS: begin
          if (is_write) begin
            resp_valid <= 1'b1;
          end else begin
            cnt <= 2'(READ_LAT - 1);
          end
        end
        WAIT: begin
          // Last WAIT cycle is exactly when the BRAM output becomes valid.
          if (cnt == 2'd0) begin
            resp_rdata <= mem_rdata;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
